// File: rtl/record_serializer_if.sv
// Handshake bundle between record producers, the serializer and the word consumer.
// The DUT side is the slave modport; producer/consumer logic uses master.
interface record_serializer_if #(
    parameter int WordSize    = 8,
    parameter int RecordWords = 16
);
    localparam int RecordSizeBits = WordSize * RecordWords;

    logic                      rec_valid;
    logic [RecordSizeBits-1:0] rec_data;
    logic                      rec_ready;
    logic                      word_valid;
    logic [WordSize-1:0]       word_data;
    logic                      word_first;
    logic                      word_last;
    logic                      word_ready;

    modport master (
        output rec_valid, rec_data, word_ready,
        input  rec_ready, word_valid, word_data, word_first, word_last
    );

    modport slave (
        input  rec_valid, rec_data, word_ready,
        output rec_ready, word_valid, word_data, word_first, word_last
    );
endinterface

// File: rtl/record_serializer.sv
// Buffers whole records and emits them word 0 first, one word per cycle.
// Word layout matches the receive-side record assembler bit for bit.
module record_serializer #(
    parameter  int WordSize       = 8,
    parameter  int RecordWords    = 16,
    parameter  int Depth          = 2,
    localparam int RecordSizeBits = WordSize * RecordWords,
    localparam int LevelBits      = $clog2(Depth) + 1,
    localparam int IdxBits        = $clog2(RecordWords),
    localparam int PtrBits        = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    record_serializer_if.slave   bus,
    output logic                 empty,
    output logic [LevelBits-1:0] level,
    output logic [15:0]          sent_count
);

    logic [RecordSizeBits-1:0] mem [Depth];
    logic [PtrBits-1:0]        wr_ptr;
    logic [PtrBits-1:0]        rd_ptr;
    logic [IdxBits-1:0]        word_idx;

    logic push;
    logic pop_word;
    logic pop_rec;
    logic last_idx;

    function automatic logic [PtrBits-1:0] next_ptr(input logic [PtrBits-1:0] p);
        return (p == PtrBits'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // rec_ready looks only at the registered level, so a full buffer never
    // accepts a record in the same cycle as the freeing pop.
    assign bus.rec_ready  = !rst && (level < LevelBits'(Depth));
    assign bus.word_valid = (level != '0);
    assign bus.word_data  = mem[rd_ptr][word_idx*WordSize +: WordSize];
    assign last_idx       = (word_idx == IdxBits'(RecordWords - 1));
    assign bus.word_first = bus.word_valid && (word_idx == '0);
    assign bus.word_last  = bus.word_valid && last_idx;
    assign empty          = (level == '0);

    assign push     = bus.rec_valid && bus.rec_ready;
    assign pop_word = bus.word_valid && bus.word_ready;
    assign pop_rec  = pop_word && last_idx;

    // NOTE: the record array has no reset; contents are only visible once
    // level says they are valid, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rec_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_idx   <= '0;
            level      <= '0;
            sent_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_word) begin
                word_idx <= pop_rec ? '0 : word_idx + 1'b1;
            end
            if (pop_rec) begin
                rd_ptr     <= next_ptr(rd_ptr);
                sent_count <= sent_count + 16'd1;
            end
            // Simultaneous push and record completion leaves level unchanged.
            case ({push, pop_rec})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule
